uart_mmio_peripheral: RTL and testbench

//   Memory-mapped UART peripheral driven by the core's memory-control decoder.

---
 rtl/uart_mmio_peripheral.sv | 192 +++++++++++++++++++
 tb/tb_uart_mmio_peripheral.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART: store-triggered transmitter, sampled receiver with a sticky
// ready flag, and zero-latency read-back words for the core's read mux.
`timescale 1ns/1ps
module uart_mmio_peripheral #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Tx_MemWrite,
  input  logic                  Tx_data_Memwrite,
  input  logic                  Clean_rx_Memwrite,
  output logic [DATA_WIDTH-1:0] Rx_ReadData,
  output logic [DATA_WIDTH-1:0] Rx_ready_ReadData,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  tx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_byte;
  logic [7:0]       r_tx_shift;
  logic             r_tx_line;
  logic             r_tx_busy;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [1:0]       r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_rx_byte;
  logic             r_rx_ready;

  logic             w_rx_good;
  logic             w_unused_wdata;

  assign w_unused_wdata = &{1'b0, WriteData[DATA_WIDTH-1:8]};

  // Line level and busy are registered alongside the FSM so uart_tx never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_byte  <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      if (Tx_data_Memwrite) r_tx_byte <= WriteData[7:0];
      case (r_tx_state)
        S_IDLE: begin
          if (Tx_MemWrite && WriteData[0]) begin
            r_tx_shift <= r_tx_byte;
            r_tx_cnt   <= BIT_RELOAD;
            r_tx_line  <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt   <= BIT_RELOAD;
            r_tx_bit   <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt   <= BIT_RELOAD;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_line <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: begin
          if (r_tx_cnt == '0) begin
            r_tx_busy  <= 1'b0;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx_good = (r_rx_state == S_STOP) && (r_rx_cnt == '0) && r_rx_sync;

  // The half-bit load on the start edge puts every later sample near a bit centre.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_cnt   <= HALF_RELOAD;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_sync) begin
              r_rx_state <= S_IDLE;
            end else begin
              r_rx_cnt   <= BIT_RELOAD;
              r_rx_bit   <= '0;
              r_rx_state <= S_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_cnt   <= BIT_RELOAD;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        default: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_sync) r_rx_byte <= r_rx_shift;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // A byte landing in the same cycle as a clear must not be lost, so set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_ready <= 1'b0;
    end else if (w_rx_good) begin
      r_rx_ready <= 1'b1;
    end else if (Clean_rx_Memwrite) begin
      r_rx_ready <= 1'b0;
    end
  end

  assign uart_tx           = r_tx_line;
  assign tx_busy           = r_tx_busy;
  assign Rx_ReadData       = {{(DATA_WIDTH-8){1'b0}}, r_rx_byte};
  assign Rx_ready_ReadData = {{(DATA_WIDTH-1){1'b0}}, r_rx_ready};

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Directed bench for uart_mmio_peripheral with 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_mmio_peripheral;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteData;
  logic        Tx_MemWrite;
  logic        Tx_data_Memwrite;
  logic        Clean_rx_Memwrite;
  logic [31:0] Rx_ReadData;
  logic [31:0] Rx_ready_ReadData;
  logic        uart_rx;
  logic        uart_tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  uart_mmio_peripheral #(
    .DATA_WIDTH(32),
    .CLK_FREQ  (16),
    .BAUD_RATE (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .WriteData        (WriteData),
    .Tx_MemWrite      (Tx_MemWrite),
    .Tx_data_Memwrite (Tx_data_Memwrite),
    .Clean_rx_Memwrite(Clean_rx_Memwrite),
    .Rx_ReadData      (Rx_ReadData),
    .Rx_ready_ReadData(Rx_ready_ReadData),
    .uart_rx          (uart_rx),
    .uart_tx          (uart_tx),
    .tx_busy          (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tx_load(input logic [7:0] b);
    WriteData        = {24'h0, b};
    Tx_data_Memwrite = 1'b1;
    tick(1);
    Tx_data_Memwrite = 1'b0;
    WriteData        = '0;
  endtask

  task automatic tx_start();
    WriteData   = 32'h1;
    Tx_MemWrite = 1'b1;
    tick(1);
    Tx_MemWrite = 1'b0;
    WriteData   = '0;
  endtask

  // Called right after the accepting edge; checks early and late in every bit.
  task automatic tx_check_frame(input logic [7:0] b, input bit inject);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    chk("tx_first_edge_line", {31'h0, uart_tx}, 32'h0);
    chk("tx_first_edge_busy", {31'h0, tx_busy}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick(2);
      chk($sformatf("tx_bit%0d_early", k), {31'h0, uart_tx}, {31'h0, f[k]});
      tick(12);
      chk($sformatf("tx_bit%0d_late", k), {31'h0, uart_tx}, {31'h0, f[k]});
      if (inject && k == 2) begin
        tx_load(8'h55);
        tx_start();
      end else if (k == 9) begin
        tick(1);
        chk("tx_busy_clk159", {31'h0, tx_busy}, 32'h1);
        tick(1);
      end else begin
        tick(2);
      end
    end
    chk("tx_busy_clk160", {31'h0, tx_busy}, 32'h0);
    chk("tx_idle_line", {31'h0, uart_tx}, 32'h1);
  endtask

  // Start bit driven just after edge E0; the stop sample falls on edge E156.
  task automatic rx_frame(input logic [7:0] b, input logic stopv, input bit clean_latch);
    uart_rx = 1'b0;
    tick(16);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      tick(16);
    end
    uart_rx = stopv;
    if (clean_latch) begin
      tick(11);
      chk("rx_ready_prelatch", Rx_ready_ReadData, 32'h0);
      Clean_rx_Memwrite = 1'b1;
      tick(1);
      Clean_rx_Memwrite = 1'b0;
      tick(4);
    end else begin
      tick(16);
    end
    uart_rx = 1'b1;
    tick(4);
  endtask

  task automatic rx_clear();
    WriteData         = 32'hFFFF_FFFF;
    Clean_rx_Memwrite = 1'b1;
    tick(1);
    Clean_rx_Memwrite = 1'b0;
    WriteData         = '0;
  endtask

  initial begin
    reset             = 1'b0;
    WriteData         = '0;
    Tx_MemWrite       = 1'b0;
    Tx_data_Memwrite  = 1'b0;
    Clean_rx_Memwrite = 1'b0;
    uart_rx           = 1'b1;
    tick(3);
    chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    chk("rst_rx_data", Rx_ReadData, 32'h0);
    chk("rst_rx_ready", Rx_ready_ReadData, 32'h0);
    reset = 1'b1;
    tick(2);
    chk("post_rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("post_rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    chk("post_rst_rx_data", Rx_ReadData, 32'h0);
    chk("post_rst_rx_ready", Rx_ready_ReadData, 32'h0);

    tx_load(8'hA5);
    tx_start();
    tx_check_frame(8'hA5, 1'b0);

    WriteData   = 32'h2;
    Tx_MemWrite = 1'b1;
    tick(1);
    Tx_MemWrite = 1'b0;
    WriteData   = '0;
    chk("tx_start_bit0_clear_busy", {31'h0, tx_busy}, 32'h0);
    chk("tx_start_bit0_clear_line", {31'h0, uart_tx}, 32'h1);

    tx_load(8'h3C);
    tx_start();
    tx_check_frame(8'h3C, 1'b1);
    tick(5);
    chk("tx_no_queue_busy", {31'h0, tx_busy}, 32'h0);
    chk("tx_no_queue_line", {31'h0, uart_tx}, 32'h1);
    tx_start();
    tx_check_frame(8'h55, 1'b0);

    rx_frame(8'h5A, 1'b1, 1'b0);
    chk("rx_5a_ready", Rx_ready_ReadData, 32'h1);
    chk("rx_5a_data", Rx_ReadData, 32'h5A);
    rx_clear();
    chk("rx_clear_ready", Rx_ready_ReadData, 32'h0);
    chk("rx_clear_data", Rx_ReadData, 32'h5A);

    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    chk("rx_glitch_ready", Rx_ready_ReadData, 32'h0);
    chk("rx_glitch_data", Rx_ReadData, 32'h5A);

    rx_frame(8'h33, 1'b0, 1'b0);
    tick(40);
    chk("rx_framing_ready", Rx_ready_ReadData, 32'h0);
    chk("rx_framing_data", Rx_ReadData, 32'h5A);

    rx_frame(8'hC3, 1'b1, 1'b0);
    chk("rx_c3_ready", Rx_ready_ReadData, 32'h1);
    chk("rx_c3_data", Rx_ReadData, 32'hC3);
    rx_clear();
    chk("rx_c3_clear_ready", Rx_ready_ReadData, 32'h0);

    rx_frame(8'h81, 1'b1, 1'b1);
    chk("rx_set_wins_ready", Rx_ready_ReadData, 32'h1);
    chk("rx_set_wins_data", Rx_ReadData, 32'h81);

    rx_frame(8'h7E, 1'b1, 1'b0);
    chk("rx_overrun_ready", Rx_ready_ReadData, 32'h1);
    chk("rx_overrun_data", Rx_ReadData, 32'h7E);

    tx_start();
    tick(5);
    chk("tx_midframe_line", {31'h0, uart_tx}, 32'h0);
    chk("tx_midframe_busy", {31'h0, tx_busy}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("async_rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    chk("async_rst_rx_data", Rx_ReadData, 32'h0);
    chk("async_rst_rx_ready", Rx_ready_ReadData, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(20);
    chk("after_rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("after_rst_tx_busy", {31'h0, tx_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
